// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: address map, op encodings, mstatus bits, irq codes.
// Latency: n/a (package); backpressure: n/a.
package csr_pkg;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } csr_op_e;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MPP_LO   = 11;
    localparam int MPP_HI   = 12;

    localparam int IRQ_MSI = 3;
    localparam int IRQ_MTI = 7;
    localparam int IRQ_MEI = 11;

    localparam logic [1:0]  MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0]  MTVEC_VECTORED = 2'b01;
    localparam logic [1:0]  MPP_MACHINE    = 2'b11;
    localparam logic [31:0] MSTATUS_RST    = 32'h0000_1800;

    // Read-modify-write result; 00 behaves as a plain write.
    function automatic logic [63:0] apply_op(input csr_op_e op, input logic [63:0] old,
                                             input logic [63:0] wd);
        case (op)
            OP_SET:   return old | wd;
            OP_CLEAR: return old & ~wd;
            default:  return wd;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent half loads; a load wins over the increment that cycle.
// Latency: 1 cycle from inc/load to value; backpressure: none.
module csr_counter64 #(
    parameter bit ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [63:0] wdata,
    output logic [63:0] value
);

    logic [63:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) cnt[31:0]  <= wdata[31:0];
            if (wr_hi) cnt[63:32] <= wdata[63:32];
        end else if (inc) begin
            cnt <= cnt + 64'd1;
        end
    end

    assign value = ENABLE ? cnt : 64'd0;

endmodule

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: combinational reads, writes/trap/mret commit on the next clk edge.
// Latency: reads 0 cycles, updates 1 cycle; backpressure: none (every request is accepted or dropped).
module csr_file_m
    import csr_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit HAS_COUNTERS = 1'b1,
    parameter bit VECTORED_EN  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     raddr,
    output logic [XLEN-1:0] rdata,
    input  logic [11:0]     waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            csr_we,
    input  logic [1:0]      csr_op,
    output logic            illegal,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_req,
    input  logic            instret,
    input  logic            ext_irq,
    input  logic            sw_irq,
    input  logic            timer_irq,
    output logic            irq_pending,
    output logic [XLEN-1:0] irq_cause,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mstatus_o
);

    localparam logic [XLEN-1:0] IRQ_MASK = XLEN'(12'h888);

    logic            mie_b, mpie_b;
    logic [XLEN-1:0] mie_r, mtvec_r, mscratch_r, mepc_r, mcause_r, mtval_r;
    logic [63:0]     mcycle, minstret;
    logic [XLEN-1:0] mstatus_v, misa_v, mip_v, pend;
    logic [XLEN-1:0] wr_old, wval;
    logic [63:0]     wval64, cnt_wd;
    logic            wr_rw, wr_ok;
    logic [1:0]      new_mode;
    logic [XLEN-1:0] tvec_base;
    logic            cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;

    function automatic logic csr_mapped(input logic [11:0] a);
        case (a)
            A_MSTATUS, A_MISA, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL,
            A_MIP, A_MCYCLE, A_MINSTRET, A_CYCLE, A_INSTRET:
                return 1'b1;
            A_MCYCLEH, A_MINSTRETH, A_CYCLEH, A_INSTRETH:
                return (XLEN == 32);
            default:
                return 1'b0;
        endcase
    endfunction

    function automatic logic csr_rw(input logic [11:0] a);
        case (a)
            A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL:
                return 1'b1;
            A_MCYCLE, A_MINSTRET:
                return HAS_COUNTERS;
            A_MCYCLEH, A_MINSTRETH:
                return HAS_COUNTERS && (XLEN == 32);
            default:
                return 1'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] csr_read(input logic [11:0] a);
        case (a)
            A_MSTATUS:             return mstatus_v;
            A_MISA:                return misa_v;
            A_MIE:                 return mie_r;
            A_MTVEC:               return mtvec_r;
            A_MSCRATCH:            return mscratch_r;
            A_MEPC:                return mepc_r;
            A_MCAUSE:              return mcause_r;
            A_MTVAL:               return mtval_r;
            A_MIP:                 return mip_v;
            A_MCYCLE, A_CYCLE:     return mcycle[XLEN-1:0];
            A_MINSTRET, A_INSTRET: return minstret[XLEN-1:0];
            A_MCYCLEH, A_CYCLEH:   return (XLEN == 32) ? XLEN'(mcycle[63:32]) : '0;
            A_MINSTRETH, A_INSTRETH:
                                   return (XLEN == 32) ? XLEN'(minstret[63:32]) : '0;
            default:               return '0;
        endcase
    endfunction

    always_comb begin
        mstatus_v                 = '0;
        mstatus_v[MPP_HI:MPP_LO]  = MPP_MACHINE;
        mstatus_v[MPIE_BIT]       = mpie_b;
        mstatus_v[MIE_BIT]        = mie_b;

        misa_v                    = '0;
        misa_v[XLEN-1:XLEN-2]     = (XLEN == 64) ? 2'b10 : 2'b01;
        misa_v[8]                 = 1'b1;

        mip_v                     = '0;
        mip_v[IRQ_MEI]            = ext_irq;
        mip_v[IRQ_MTI]            = timer_irq;
        mip_v[IRQ_MSI]            = sw_irq;
    end

    always_comb begin
        rdata   = csr_read(raddr);
        wr_old  = csr_read(waddr);
        wr_rw   = csr_rw(waddr);
        illegal = !csr_mapped(raddr) || (csr_we && !wr_rw);
        wr_ok   = csr_we && wr_rw && !trap_req && !mret_req;

        wval64  = apply_op(csr_op_e'(csr_op), 64'(wr_old), 64'(wdata));
        wval    = wval64[XLEN-1:0];

        // Counter halves both take the XLEN-wide operand; the strobe picks the half.
        cnt_wd  = 64'(wval);
        if (XLEN == 32) cnt_wd[63:32] = cnt_wd[31:0];

        new_mode = (VECTORED_EN && wval[1:0] == MTVEC_VECTORED) ? MTVEC_VECTORED : MTVEC_DIRECT;
    end

    assign cyc_wr_lo = wr_ok && (waddr == A_MCYCLE);
    assign cyc_wr_hi = wr_ok && ((waddr == A_MCYCLEH) || (XLEN == 64 && waddr == A_MCYCLE));
    assign ins_wr_lo = wr_ok && (waddr == A_MINSTRET);
    assign ins_wr_hi = wr_ok && ((waddr == A_MINSTRETH) || (XLEN == 64 && waddr == A_MINSTRET));

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_b      <= MSTATUS_RST[MIE_BIT];
            mpie_b     <= MSTATUS_RST[MPIE_BIT];
            mie_r      <= '0;
            mtvec_r    <= '0;
            mscratch_r <= '0;
            mepc_r     <= '0;
            mcause_r   <= '0;
            mtval_r    <= '0;
        end else if (trap_req) begin
            mepc_r   <= {trap_pc[XLEN-1:2], 2'b00};
            mcause_r <= trap_cause;
            mtval_r  <= trap_tval;
            mpie_b   <= mie_b;
            mie_b    <= 1'b0;
        end else if (mret_req) begin
            mie_b  <= mpie_b;
            mpie_b <= 1'b1;
        end else if (wr_ok) begin
            case (waddr)
                A_MSTATUS: begin
                    mie_b  <= wval[MIE_BIT];
                    mpie_b <= wval[MPIE_BIT];
                end
                A_MIE:      mie_r      <= wval & IRQ_MASK;
                A_MTVEC:    mtvec_r    <= {wval[XLEN-1:2], new_mode};
                A_MSCRATCH: mscratch_r <= wval;
                A_MEPC:     mepc_r     <= {wval[XLEN-1:2], 2'b00};
                A_MCAUSE:   mcause_r   <= wval;
                A_MTVAL:    mtval_r    <= wval;
                default: ;
            endcase
        end
    end

    csr_counter64 #(.ENABLE(HAS_COUNTERS)) u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (cyc_wr_lo),
        .wr_hi (cyc_wr_hi),
        .wdata (cnt_wd),
        .value (mcycle)
    );

    csr_counter64 #(.ENABLE(HAS_COUNTERS)) u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (instret),
        .wr_lo (ins_wr_lo),
        .wr_hi (ins_wr_hi),
        .wdata (cnt_wd),
        .value (minstret)
    );

    // Vectoring applies only to interrupt causes; exceptions always land on base.
    always_comb begin
        tvec_base   = {mtvec_r[XLEN-1:2], 2'b00};
        trap_vector = tvec_base;
        if (mtvec_r[1:0] == MTVEC_VECTORED && trap_cause[XLEN-1])
            trap_vector = tvec_base + XLEN'({trap_cause[5:0], 2'b00});
    end

    always_comb begin
        pend        = mip_v & mie_r;
        irq_pending = mie_b && (|pend);
        irq_cause   = '0;
        if (pend[IRQ_MEI]) begin
            irq_cause[XLEN-1] = 1'b1;
            irq_cause[5:0]    = 6'(IRQ_MEI);
        end else if (pend[IRQ_MSI]) begin
            irq_cause[XLEN-1] = 1'b1;
            irq_cause[5:0]    = 6'(IRQ_MSI);
        end else if (pend[IRQ_MTI]) begin
            irq_cause[XLEN-1] = 1'b1;
            irq_cause[5:0]    = 6'(IRQ_MTI);
        end
    end

    assign mepc_o    = mepc_r;
    assign mstatus_o = mstatus_v;

endmodule
